// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: load/store funct3 encoding, access FSM states and pipeline records.
package mem_stage_pkg;

   localparam int XLEN = 64;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_D  = 3'b011,
      F3_BU = 3'b100,
      F3_HU = 3'b101,
      F3_WU = 3'b110,
      F3_DU = 3'b111
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] wdata;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      funct3_t         funct3;
   } exmem_t;

   typedef struct packed {
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] rdata;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_to_reg;
      logic            misalign;
   } memwb_t;

   // Byte-enable pattern for an access of this size, before shifting to its lane.
   function automatic logic [7:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'b000;
         2'b01:   return 3'b001;
         2'b10:   return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: ready/valid request on a doubleword-aligned address.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic            DMemReq;
   logic            DMemWe;
   logic [XLEN-1:0] DMemAddr;
   logic [XLEN-1:0] DMemWData;
   logic [7:0]      DMemBe;
   logic            DMemReady;
   logic [XLEN-1:0] DMemRData;

   modport master (
      output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
      input  DMemReady, DMemRData
   );

   modport slave (
      input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
      output DMemReady, DMemRData
   );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Load formatter: pulls the addressed bytes out of a read doubleword and sign/zero-extends them.
module load_extend
   import mem_stage_pkg::*;
(
   input  funct3_t         funct3_i,
   input  logic [2:0]      lane_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] shifted;

   // Bytes beyond lane 7 shift in as zero; there is no cross-doubleword split.
   assign shifted = rdata_i >> {lane_i, 3'b000};

   always_comb begin
      case (funct3_i)
         F3_B:    data_o = {{56{shifted[7]}},  shifted[7:0]};
         F3_H:    data_o = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    data_o = {{32{shifted[31]}}, shifted[31:0]};
         F3_BU:   data_o = {56'd0, shifted[7:0]};
         F3_HU:   data_o = {48'd0, shifted[15:0]};
         F3_WU:   data_o = {32'd0, shifted[31:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV64I+Zba core: EX/MEM register, data-memory access FSM and MEM/WB register.
// Define MEM_MISALIGN_CHECK_EN to trap non size-aligned H/W/D accesses instead of issuing them.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  ALUResult_E,
   input  logic [XLEN-1:0]  WriteData_E,
   input  logic [4:0]       Rd_E,
   input  logic             RegWrite_E,
   input  logic             MemRead_E,
   input  logic             MemWrite_E,
   input  logic [2:0]       Funct3_E,
   mem_stage_if.master      dmem,
   output logic             Stall_M,
   output logic [XLEN-1:0]  ALUResult_W,
   output logic [XLEN-1:0]  ReadData_W,
   output logic [4:0]       Rd_W,
   output logic             RegWrite_W,
   output logic             MemToReg_W,
   output logic             MisalignErr_W
);

   exmem_t          m_q, m_d;
   memwb_t          wb_q, wb_d;
   mem_state_t      state_q, state_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [XLEN-1:0] load_data;
   logic [2:0]      lane;
   logic            mem_op;
   logic            misalign;
   logic            req;

   assign mem_op = m_q.mem_read | m_q.mem_write;
   assign lane   = m_q.alu[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = mem_op & (|(lane & align_mask(m_q.funct3)));
`else
   assign misalign = 1'b0;
`endif

   // ---------------- access FSM ----------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_op) state_d = (misalign || dmem.DMemReady) ? DONE : WAIT;
         WAIT:    if (dmem.DMemReady) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Stall_M = 1'b0;
      req     = 1'b0;
      case (state_q)
         IDLE: begin
            Stall_M = mem_op;
            req     = mem_op & ~misalign;
         end
         WAIT: begin
            Stall_M = 1'b1;
            req     = 1'b1;
         end
         default: ;
      endcase
   end

   // Bus fields come straight from the held EX/MEM register, so they stay stable while waiting.
   assign dmem.DMemReq   = req;
   assign dmem.DMemWe    = req & m_q.mem_write;
   assign dmem.DMemAddr  = {m_q.alu[XLEN-1:3], 3'b000};
   assign dmem.DMemWData = m_q.wdata << {lane, 3'b000};
   assign dmem.DMemBe    = (req & m_q.mem_write) ? (size_mask(m_q.funct3) << lane) : 8'h00;

   assign rdata_d = (req & dmem.DMemReady & ~m_q.mem_write) ? dmem.DMemRData : rdata_q;

   load_extend u_load_extend (
      .funct3_i (m_q.funct3),
      .lane_i   (lane),
      .rdata_i  (rdata_q),
      .data_o   (load_data)
   );

   // ---------------- pipeline registers ----------------
   always_comb begin
      m_d = m_q;
      if (!Stall_M) begin
         m_d.alu       = ALUResult_E;
         m_d.wdata     = WriteData_E;
         m_d.rd        = Rd_E;
         m_d.reg_write = RegWrite_E;
         m_d.mem_read  = MemRead_E;
         m_d.mem_write = MemWrite_E;
         m_d.funct3    = funct3_t'(Funct3_E);
      end
   end

   // A stalled cycle sends a bubble to W; data fields keep their last value.
   always_comb begin
      wb_d = wb_q;
      if (Stall_M) begin
         wb_d.reg_write  = 1'b0;
         wb_d.mem_to_reg = 1'b0;
         wb_d.misalign   = 1'b0;
      end else begin
         wb_d.alu        = m_q.alu;
         wb_d.rdata      = load_data;
         wb_d.rd         = m_q.rd;
         wb_d.reg_write  = m_q.reg_write & ~misalign;
         wb_d.mem_to_reg = m_q.mem_read;
         wb_d.misalign   = misalign;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q     <= '0;
         wb_q    <= '0;
         rdata_q <= '0;
      end else begin
         m_q     <= m_d;
         wb_q    <= wb_d;
         rdata_q <= rdata_d;
      end
   end

   assign ALUResult_W   = wb_q.alu;
   assign ReadData_W    = wb_q.rdata;
   assign Rd_W          = wb_q.rd;
   assign RegWrite_W    = wb_q.reg_write;
   assign MemToReg_W    = wb_q.mem_to_reg;
   assign MisalignErr_W = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: instruction-level model with byte memory, per-cycle compare.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic [63:0] ALUResult_E, WriteData_E;
   logic [4:0]  Rd_E;
   logic        RegWrite_E, MemRead_E, MemWrite_E;
   logic [2:0]  Funct3_E;
   logic        Stall_M;
   logic [63:0] ALUResult_W, ReadData_W;
   logic [4:0]  Rd_W;
   logic        RegWrite_W, MemToReg_W, MisalignErr_W;

   mem_stage_if dmem ();

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .ALUResult_E   (ALUResult_E),
      .WriteData_E   (WriteData_E),
      .Rd_E          (Rd_E),
      .RegWrite_E    (RegWrite_E),
      .MemRead_E     (MemRead_E),
      .MemWrite_E    (MemWrite_E),
      .Funct3_E      (Funct3_E),
      .dmem          (dmem),
      .Stall_M       (Stall_M),
      .ALUResult_W   (ALUResult_W),
      .ReadData_W    (ReadData_W),
      .Rd_W          (Rd_W),
      .RegWrite_W    (RegWrite_W),
      .MemToReg_W    (MemToReg_W),
      .MisalignErr_W (MisalignErr_W)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] alu, wdata;
      logic [4:0]  rd;
      logic        rw, mr, mw;
      logic [2:0]  f3;
   } ins_t;

   typedef struct {
      bit          full;
      logic        rw, m2r, mis;
      logic [4:0]  rd;
      logic [63:0] alu, rdata;
      bit          chk_rdata;
   } w_t;

   typedef struct {
      logic        stall, req;
      bit          chk_bus, chk_wdata;
      logic        we;
      logic [63:0] addr, wdata;
      logic [7:0]  be;
      w_t          w;
   } exp_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        exp_q[$];
   exp_t        ce;
   w_t          pend_w;
   logic [7:0]  mem_m [bit [63:0]];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input int lane, input logic [63:0] dw);
      logic [63:0] v = '0;
      int n = size_of(f3);
      for (int b = 0; b < n; b++)
         if (lane + b < 8) v[8*b +: 8] = dw[8*(lane+b) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
         for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] store_be(input logic [2:0] f3, input int lane);
      logic [7:0] be = '0;
      for (int b = 0; b < size_of(f3); b++)
         if (lane + b < 8) be[lane+b] = 1'b1;
      return be;
   endfunction

   function automatic bit misaligned(input ins_t x);
`ifdef MEM_MISALIGN_CHECK_EN
      return (x.mr || x.mw) && ((int'(x.alu[2:0]) % size_of(x.f3)) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [63:0] rd_dword(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int b = 0; b < 8; b++)
         if (mem_m.exists(a + 64'(b))) v[8*b +: 8] = mem_m[a + 64'(b)];
      return v;
   endfunction

   function automatic ins_t mk(input logic [2:0] f3, input logic mr, input logic mw, input logic rw,
                               input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] wd);
      ins_t x;
      x.f3 = f3; x.mr = mr; x.mw = mw; x.rw = rw; x.rd = rd; x.alu = alu; x.wdata = wd;
      return x;
   endfunction

   function automatic w_t bubble_w();
      w_t w;
      w.full = 0; w.rw = 0; w.m2r = 0; w.mis = 0; w.rd = '0; w.alu = '0; w.rdata = '0; w.chk_rdata = 0;
      return w;
   endfunction

   function automatic exp_t new_exp(input logic stall, input logic req);
      exp_t e;
      e.stall = stall; e.req = req; e.chk_bus = 0; e.chk_wdata = 0;
      e.we = 0; e.addr = '0; e.wdata = '0; e.be = '0; e.w = pend_w;
      return e;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive_e(input ins_t x);
      ALUResult_E = x.alu;  WriteData_E = x.wdata; Rd_E = x.rd;
      RegWrite_E  = x.rw;   MemRead_E   = x.mr;    MemWrite_E = x.mw; Funct3_E = x.f3;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      rst = 1'b1;
      drive_e(mk(3'b000, 0, 0, 0, 5'd0, 64'd0, 64'd0));
      dmem.DMemReady = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         e = new_exp(1'b0, 1'b0);
         e.chk_bus = 1; e.chk_wdata = 1;
         e.w = bubble_w();
         e.w.full = 1; e.w.chk_rdata = 1;
         exp_q.push_back(e);
      end
      rst = 1'b0;
      pend_w = bubble_w();
      pend_w.full = 1;
   endtask

   // Issues x into M; memory answers ready d cycles after the first request cycle.
   task automatic issue(input ins_t x, input int d);
      exp_t        e;
      w_t          ret;
      bit          mis;
      int          lane;
      logic [63:0] dwa, ld;
      drive_e(x);
      @(posedge clk); #1;
      drive_e(mk(3'b000, 0, 0, 0, 5'd0, 64'd0, 64'd0));
      mis  = misaligned(x);
      lane = int'(x.alu[2:0]);
      dwa  = {x.alu[63:3], 3'b000};
      ld   = '0;
      if (x.mr || x.mw) begin
         if (mis) begin
            exp_q.push_back(new_exp(1'b1, 1'b0));
            pend_w = bubble_w();
            @(posedge clk); #1;
         end else begin
            for (int i = 0; i <= d; i++) begin
               e = new_exp(1'b1, 1'b1);
               e.chk_bus = 1; e.chk_wdata = x.mw; e.we = x.mw; e.addr = dwa;
               e.be = x.mw ? store_be(x.f3, lane) : 8'h00;
               e.wdata = x.wdata << (8 * lane);
               dmem.DMemReady = (i == d);
               dmem.DMemRData = (i == d) ? rd_dword(dwa) : {$urandom, $urandom};
               if (i == d) ld = model_load(x.f3, lane, rd_dword(dwa));
               exp_q.push_back(e);
               pend_w = bubble_w();
               @(posedge clk); #1;
            end
            dmem.DMemReady = 1'b0;
            if (x.mw)
               for (int b = 0; b < size_of(x.f3); b++)
                  if (lane + b < 8) mem_m[dwa + 64'(lane + b)] = x.wdata[8*b +: 8];
         end
      end
      ret.full = 1; ret.rw = x.rw & ~mis; ret.m2r = x.mr; ret.mis = mis; ret.rd = x.rd;
      ret.alu = x.alu; ret.rdata = ld; ret.chk_rdata = x.mr & ~mis;
      exp_q.push_back(new_exp(1'b0, 1'b0));
      pend_w = ret;
   endtask

   // Issues a load and resets the stage while the memory is still withholding ready.
   task automatic issue_abort(input ins_t x, input int n);
      exp_t e;
      drive_e(x);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         e = new_exp(1'b1, 1'b1);
         e.chk_bus = 1; e.addr = {x.alu[63:3], 3'b000};
         dmem.DMemReady = 1'b0;
         exp_q.push_back(e);
         pend_w = bubble_w();
      end
      do_reset(1);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         ce = exp_q.pop_front();
         check("Stall_M", Stall_M, ce.stall);
         check("DMemReq", dmem.DMemReq, ce.req);
         if (ce.chk_bus) begin
            check("DMemWe",   dmem.DMemWe,   ce.we);
            check("DMemAddr", dmem.DMemAddr, ce.addr);
            check("DMemBe",   dmem.DMemBe,   ce.be);
            if (ce.chk_wdata) check("DMemWData", dmem.DMemWData, ce.wdata);
         end
         check("RegWrite_W", RegWrite_W, ce.w.rw);
         if (ce.w.full) begin
            check("Rd_W",          Rd_W,          ce.w.rd);
            check("ALUResult_W",   ALUResult_W,   ce.w.alu);
            check("MemToReg_W",    MemToReg_W,    ce.w.m2r);
            check("MisalignErr_W", MisalignErr_W, ce.w.mis);
            if (ce.w.chk_rdata) check("ReadData_W", ReadData_W, ce.w.rdata);
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      dmem.DMemReady = 1'b0;
      dmem.DMemRData = '0;
      drive_e(mk(3'b000, 0, 0, 0, 5'd0, 64'd0, 64'd0));
      pend_w = bubble_w();

      // Hand-computed pins on the model itself.
      check("model_lb_sext",   model_load(3'b000, 5, 64'h0000_8000_0000_0000), 64'hFFFF_FFFF_FFFF_FF80);
      check("model_lbu_zext",  model_load(3'b100, 5, 64'h0000_8000_0000_0000), 64'h0000_0000_0000_0080);
      check("model_lwu_trunc", model_load(3'b110, 6, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);
      check("model_be_sb",     store_be(3'b000, 3), 8'h08);
      check("model_be_sd",     store_be(3'b011, 0), 8'hFF);
      check("model_be_sw_l6",  store_be(3'b010, 6), 8'hC0);

      do_reset(2);

      mem_m[64'h2005] = 8'h80;
      issue(mk(3'b011, 0, 1, 0, 5'd5,  64'h1000, 64'h1122_3344_5566_7788), 0); // SD
      issue(mk(3'b000, 0, 1, 0, 5'd0,  64'h1003, 64'h0000_0000_0000_00AB), 0); // SB
      issue(mk(3'b000, 1, 0, 1, 5'd6,  64'h2005, 64'd0), 1);                   // LB
      issue(mk(3'b100, 1, 0, 1, 5'd7,  64'h2005, 64'd0), 0);                   // LBU
      issue(mk(3'b010, 1, 0, 1, 5'd8,  64'h1000, 64'd0), 3);                   // LW, slow memory
      issue(mk(3'b000, 0, 0, 1, 5'd9,  64'h1234, 64'h5555), 0);                // ADD
      issue(mk(3'b011, 1, 0, 1, 5'd10, 64'h1000, 64'd0), 1);                   // LD
      issue(mk(3'b000, 0, 0, 1, 5'd11, 64'hCAFE, 64'd0), 0);                   // ADD
      issue(mk(3'b000, 0, 0, 1, 5'd16, 64'hBEEF, 64'd0), 0);                   // ADD back-to-back
      issue(mk(3'b001, 1, 0, 1, 5'd12, 64'h1001, 64'd0), 0);                   // LH, lane 1
      issue(mk(3'b010, 0, 1, 0, 5'd0,  64'h3006, 64'h0000_0000_DEAD_BEEF), 0); // SW, lane 6
      issue(mk(3'b110, 1, 0, 1, 5'd13, 64'h3006, 64'd0), 0);                   // LWU, lane 6
      issue(mk(3'b111, 1, 0, 1, 5'd14, 64'h1000, 64'd0), 2);                   // funct3 111 as LD
      issue(mk(3'b001, 1, 0, 1, 5'd17, 64'h2004, 64'd0), 0);                   // LH sign
      issue(mk(3'b101, 1, 0, 1, 5'd18, 64'h2004, 64'd0), 0);                   // LHU
      issue(mk(3'b111, 0, 1, 0, 5'd0,  64'h4000, 64'h0102_0304_0506_0708), 1); // funct3 111 as SD

      issue_abort(mk(3'b010, 1, 0, 1, 5'd19, 64'h1000, 64'd0), 2);            // rst in WAIT
      issue(mk(3'b000, 0, 0, 1, 5'd15, 64'h7777, 64'd0), 0);                   // ADD after reset
      issue(mk(3'b011, 1, 0, 1, 5'd20, 64'h4000, 64'd0), 0);                   // LD back stored SD
      issue(mk(3'b000, 0, 0, 0, 5'd0, 64'd0, 64'd0), 0);
      issue(mk(3'b000, 0, 0, 0, 5'd0, 64'd0, 64'd0), 0);

      @(negedge clk); #1;
      check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
